// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// imem_loader
//
// Upstream feeder for the instruction memory's external-load port. Instruction
// words arrive on a valid/ready stream and are packed into pairs. Each complete
// pair is written with a single-cycle strobe at consecutive addresses, starting
// at address 0 for every session. While a session runs, busy stays high so the
// fetch stage remains stalled.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   defined   -> checksum is an XOR accumulator over every accepted word,
//                cleared when a session is started.
//   undefined -> checksum is tied to zero and no accumulator is built.
//
// Parameters:
//   INS_ADDRESS        instruction memory address width
//   INS_W              instruction word width
//
// Ports:
//   clk                clock, all logic on the rising edge
//   rst_n              synchronous active-low reset
//   load_start         session start pulse (honoured only when not busy)
//   load_count         number of word pairs, saturated to 2^INS_ADDRESS
//   s_valid / s_data   stream word input
//   s_ready            loader accepts s_data this cycle
//   enable_load_ex_mem memory write strobe, one cycle per pair
//   InstExMemAddress   write address
//   InstExMemData1     first word of the pair
//   InstExMemData2     second word of the pair
//   busy               session in progress
//   done               last session completed, held until the next start
//   checksum           XOR of accepted words (see macro above)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic [INS_ADDRESS:0]   load_count,
  input  logic                   s_valid,
  input  logic [INS_W-1:0]       s_data,
  output logic                   s_ready,
  output logic                   enable_load_ex_mem,
  output logic [INS_ADDRESS-1:0] InstExMemAddress,
  output logic [INS_W-1:0]       InstExMemData1,
  output logic [INS_W-1:0]       InstExMemData2,
  output logic                   busy,
  output logic                   done,
  output logic [INS_W-1:0]       checksum
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL1 = 3'd1,
    ST_FILL2 = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Largest pair count a session may request: one write per address.
  localparam logic [INS_ADDRESS:0]   CNT_MAX  = {1'b1, {INS_ADDRESS{1'b0}}};
  localparam logic [INS_ADDRESS:0]   CNT_ONE  = {{INS_ADDRESS{1'b0}}, 1'b1};
  localparam logic [INS_ADDRESS:0]   CNT_ZERO = {(INS_ADDRESS+1){1'b0}};
  localparam logic [INS_ADDRESS-1:0] ADDR_ONE = {{(INS_ADDRESS-1){1'b0}}, 1'b1};

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic                     start_s;
  logic                     hs_fill1_s;
  logic                     hs_fill2_s;
  logic                     last_pair_s;
  logic [INS_ADDRESS:0]     count_sat_s;

  logic [INS_ADDRESS:0]     count_r;
  logic [INS_ADDRESS:0]     pair_cnt_r;
  logic [INS_ADDRESS-1:0]   addr_r;
  logic [INS_W-1:0]         data1_r;

  logic                     s_ready_r;
  logic                     enable_r;
  logic                     busy_r;
  logic                     done_r;
  logic [INS_ADDRESS-1:0]   mem_addr_r;
  logic [INS_W-1:0]         mem_data1_r;
  logic [INS_W-1:0]         mem_data2_r;

  // Saturate the requested pair count so the address never wraps in a session.
  always_comb begin
    count_sat_s = load_count;
    if (load_count > CNT_MAX) begin
      count_sat_s = CNT_MAX;
    end else begin
      count_sat_s = load_count;
    end
  end

  // The pair being written is the last one once the incremented counter
  // reaches the latched count.
  assign last_pair_s = ((pair_cnt_r + CNT_ONE) == count_r);

  // Next-state and handshake decode.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    hs_fill1_s  = 1'b0;
    hs_fill2_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (load_start) begin
          start_s = 1'b1;
          if (count_sat_s == CNT_ZERO) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_FILL1;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_FILL1: begin
        if (s_valid) begin
          hs_fill1_s  = 1'b1;
          state_nxt_s = ST_FILL2;
        end else begin
          state_nxt_s = ST_FILL1;
        end
      end
      ST_FILL2: begin
        if (s_valid) begin
          hs_fill2_s  = 1'b1;
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_FILL2;
        end
      end
      ST_WRITE: begin
        if (last_pair_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_FILL1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ready_r <= 1'b0;
      enable_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      s_ready_r <= (state_nxt_s == ST_FILL1) || (state_nxt_s == ST_FILL2);
      enable_r  <= (state_nxt_s == ST_WRITE);
      busy_r    <= (state_nxt_s == ST_FILL1) || (state_nxt_s == ST_FILL2) ||
                   (state_nxt_s == ST_WRITE);
      done_r    <= (state_nxt_s == ST_DONE);
    end
  end

  // Session count, pair counter and running address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r    <= CNT_ZERO;
      pair_cnt_r <= CNT_ZERO;
      addr_r     <= {INS_ADDRESS{1'b0}};
    end else if (start_s) begin
      count_r    <= count_sat_s;
      pair_cnt_r <= CNT_ZERO;
      addr_r     <= {INS_ADDRESS{1'b0}};
    end else if (state_r == ST_WRITE) begin
      pair_cnt_r <= pair_cnt_r + CNT_ONE;
      addr_r     <= addr_r + ADDR_ONE;
    end else begin
      pair_cnt_r <= pair_cnt_r;
      addr_r     <= addr_r;
    end
  end

  // First word of a pair waits here until its partner arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data1_r <= {INS_W{1'b0}};
    end else if (hs_fill1_s) begin
      data1_r <= s_data;
    end else begin
      data1_r <= data1_r;
    end
  end

  // Memory port registers load only when a pair completes, so address and
  // data are stable through the write cycle and hold afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr_r  <= {INS_ADDRESS{1'b0}};
      mem_data1_r <= {INS_W{1'b0}};
      mem_data2_r <= {INS_W{1'b0}};
    end else if (hs_fill2_s) begin
      mem_addr_r  <= addr_r;
      mem_data1_r <= data1_r;
      mem_data2_r <= s_data;
    end else begin
      mem_addr_r  <= mem_addr_r;
      mem_data1_r <= mem_data1_r;
      mem_data2_r <= mem_data2_r;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [INS_W-1:0] checksum_r;

  // XOR accumulator over every accepted stream word of the current session.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_r <= {INS_W{1'b0}};
    end else if (start_s) begin
      checksum_r <= {INS_W{1'b0}};
    end else if (hs_fill1_s || hs_fill2_s) begin
      checksum_r <= checksum_r ^ s_data;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = {INS_W{1'b0}};
`endif

  assign s_ready            = s_ready_r;
  assign enable_load_ex_mem = enable_r;
  assign busy               = busy_r;
  assign done               = done_r;
  assign InstExMemAddress   = mem_addr_r;
  assign InstExMemData1     = mem_data1_r;
  assign InstExMemData2     = mem_data2_r;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// Self-checking bench for imem_loader: a word/pair counting model predicts all
// outputs every cycle; directed and random sessions add literal expectations.
module tb_imem_loader;
  localparam int INS_ADDRESS = 9;
  localparam int INS_W       = 32;
  localparam int MAX_PAIRS   = 1 << INS_ADDRESS;

  logic                   clk = 1'b0;
  logic                   rst_n, load_start, s_valid;
  logic [INS_ADDRESS:0]   load_count;
  logic [INS_W-1:0]       s_data;
  logic                   s_ready, enable_load_ex_mem, busy, done;
  logic [INS_ADDRESS-1:0] InstExMemAddress;
  logic [INS_W-1:0]       InstExMemData1, InstExMemData2, checksum;

  imem_loader #(.INS_ADDRESS(INS_ADDRESS), .INS_W(INS_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_count(load_count),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .enable_load_ex_mem(enable_load_ex_mem), .InstExMemAddress(InstExMemAddress),
    .InstExMemData1(InstExMemData1), .InstExMemData2(InstExMemData2),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (counts words and pairs) --------------
  bit          m_active = 1'b0, m_done = 1'b0, m_en = 1'b0;
  int          m_cnt = 0, m_words = 0, m_writes = 0;
  logic [31:0] m_cks = 32'd0, m_w1 = 32'd0, m_w2 = 32'd0;
  int          m_addr = 0;
  logic [31:0] m_d1 = 32'd0, m_d2 = 32'd0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0; m_done = 1'b0; m_words = 0; m_writes = 0; m_cks = 32'd0;
      m_addr = 0; m_d1 = 32'd0; m_d2 = 32'd0;
    end else if (m_active) begin
      if (m_words == 2 * m_writes + 2) begin
        m_writes++;
        if (m_writes == m_cnt) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end else if (s_valid) begin
        if (m_words % 2 == 0) m_w1 = s_data;
        else                  m_w2 = s_data;
        m_words++;
        m_cks = m_cks ^ s_data;
      end
    end else if (load_start) begin
      m_cnt    = (int'(load_count) > MAX_PAIRS) ? MAX_PAIRS : int'(load_count);
      m_words  = 0;
      m_writes = 0;
      m_cks    = 32'd0;
      m_done   = (m_cnt == 0);
      m_active = (m_cnt != 0);
    end
    m_en = m_active && (m_words == 2 * m_writes + 2);
    if (m_en) begin
      m_addr = m_writes;
      m_d1   = m_w1;
      m_d2   = m_w2;
    end
  end

  // ---------------- stream source (a real valid/ready producer) -------------
  logic [31:0] src_q[$];
  int          mode = 0;
  bit          tog  = 1'b0;

  always @(posedge clk) begin
    if (rst_n && s_valid && s_ready && src_q.size() > 0) begin
      void'(src_q.pop_front());
    end
  end

  task automatic drive_stream();
    if (src_q.size() > 0) begin
      s_data = src_q[0];
      if (mode == 0) s_valid = 1'b1;
      else if (mode == 1) begin tog = ~tog; s_valid = tog; end
      else s_valid = 1'($urandom_range(0, 1));
    end else begin
      s_data  = $urandom;
      s_valid = 1'($urandom_range(0, 1));
    end
  endtask

  // ---------------- per-cycle compare + write log ---------------------------
  int          waddr[$];
  logic [31:0] wd1[$], wd2[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_ready", 64'(s_ready), 64'(m_active && !m_en));
      chk("enable",  64'(enable_load_ex_mem), 64'(m_en));
      chk("busy",    64'(busy), 64'(m_active));
      chk("done",    64'(done), 64'(m_done));
      chk("addr",    64'(InstExMemAddress), 64'(m_addr[INS_ADDRESS-1:0]));
      chk("data1",   64'(InstExMemData1), 64'(m_d1));
      chk("data2",   64'(InstExMemData2), 64'(m_d2));
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("checksum", 64'(checksum), 64'(m_cks));
`else
      chk("checksum", 64'(checksum), 64'd0);
`endif
      if (enable_load_ex_mem === 1'b1) begin
        waddr.push_back(int'(InstExMemAddress));
        wd1.push_back(InstExMemData1);
        wd2.push_back(InstExMemData2);
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic cyc();
    @(posedge clk);
    #2;
    drive_stream();
  endtask

  task automatic start(input int n);
    load_start = 1'b1;
    load_count = (INS_ADDRESS+1)'(n);
    cyc();
    load_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int k = 0;
    while (m_active && k < max_cycles) begin
      cyc();
      k++;
    end
    chk("timeout", 64'(m_active), 64'd0);
    cyc();
  endtask

  // Check the writes logged since index n0 against the words that were fed.
  task automatic chk_session(input string tag, input int n0, input int pairs,
                             input logic [31:0] words[$]);
    chk({tag, "_nwrites"}, 64'(waddr.size() - n0), 64'(pairs));
    for (int i = 0; i < pairs && (n0 + i) < waddr.size(); i++) begin
      chk({tag, "_addr"}, 64'(waddr[n0+i]), 64'(i));
      chk({tag, "_d1"},   64'(wd1[n0+i]), 64'(words[2*i]));
      chk({tag, "_d2"},   64'(wd2[n0+i]), 64'(words[2*i+1]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words[$];
    int n0, n, cks_exp;
    rst_n = 1'b0; load_start = 1'b0; load_count = '0; s_valid = 1'b0; s_data = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst_n = 1'b1;
    // Reset values, literal.
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", 64'(InstExMemAddress), 64'd0);
    chk("rst_cks",  64'(checksum), 64'd0);

    // Test 1: two pairs back to back.
    mode = 0;
    words = '{32'hA, 32'hB, 32'hC, 32'hD};
    foreach (words[i]) src_q.push_back(words[i]);
    n0 = waddr.size();
    start(2);
    wait_idle(100);
    chk_session("t1", n0, 2, words);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_cks",  64'(checksum), 64'd0);

    // Test 2: one pair with s_valid toggling.
    mode = 1;
    words = '{32'h1234_5678, 32'h9ABC_DEF0};
    foreach (words[i]) src_q.push_back(words[i]);
    n0 = waddr.size();
    start(1);
    wait_idle(100);
    chk_session("t2", n0, 1, words);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t2_cks", 64'(checksum), 64'h8888_8888);
`endif

    // Test 3: zero count.
    src_q.delete();
    n0 = waddr.size();
    start(0);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);
    cyc();
    chk("t3_nwrites", 64'(waddr.size() - n0), 64'd0);

    // Test 4: start pulse mid-session is ignored.
    mode = 2;
    words.delete();
    for (int i = 0; i < 6; i++) words.push_back($urandom);
    foreach (words[i]) src_q.push_back(words[i]);
    n0 = waddr.size();
    start(3);
    repeat (3) cyc();
    start(5);
    wait_idle(200);
    chk_session("t4", n0, 3, words);

    // Test 5: reset after the first word of a pair.
    mode = 0;
    src_q.delete();
    for (int i = 0; i < 6; i++) src_q.push_back($urandom);
    n0 = waddr.size();
    start(3);
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    src_q.delete();
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_ready", 64'(s_ready), 64'd0);
    chk("t5_nwrites", 64'(waddr.size() - n0), 64'd0);
    words = '{32'h5555_0001, 32'h5555_0002};
    foreach (words[i]) src_q.push_back(words[i]);
    n0 = waddr.size();
    start(1);
    wait_idle(100);
    chk_session("t5", n0, 1, words);

    // Test 6: count saturates to 512 pairs.
    mode = 0;
    words.delete();
    for (int i = 0; i < 2 * MAX_PAIRS; i++) words.push_back($urandom);
    foreach (words[i]) src_q.push_back(words[i]);
    n0 = waddr.size();
    start(1023);
    wait_idle(4000);
    chk_session("t6", n0, MAX_PAIRS, words);
    chk("t6_last_addr", 64'(waddr[waddr.size()-1]), 64'd511);
    chk("t6_done", 64'(done), 64'd1);

    // Random sessions.
    for (int it = 0; it < 10; it++) begin
      mode = $urandom_range(0, 2);
      n = $urandom_range(0, 12);
      src_q.delete();
      words.delete();
      cks_exp = 0;
      for (int i = 0; i < 2 * n; i++) begin
        words.push_back($urandom);
        cks_exp = cks_exp ^ int'(words[i]);
      end
      foreach (words[i]) src_q.push_back(words[i]);
      n0 = waddr.size();
      start(n);
      if (n > 2 && $urandom_range(0, 1) == 1) begin
        repeat (2) cyc();
        start($urandom_range(1, 20));
      end
      wait_idle(500);
      chk_session("rnd", n0, n, words);
      chk("rnd_done", 64'(done), 64'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("rnd_cks", 64'(checksum), 64'(cks_exp));
`endif
      repeat ($urandom_range(0, 3)) cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Upstream feeder for the instruction memory. Accepts a stream of instruction words over a valid/ready interface, packs them into word pairs, and issues one single-cycle write per pair on the instruction memory's external-load port (`enable_load_ex_mem`, `InstExMemAddress`, `InstExMemData1`, `InstExMemData2`). While a load session runs it holds `busy` high so the fetch stage stays stalled.

## Interface

Parameters:
- `INS_ADDRESS`, default 9: instruction memory address width.
- `INS_W`, default 32: instruction word width.

Ports:
- `clk`  in  1: clock, all logic on rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `load_start`  in  1: pulse that begins a session. Sampled only in IDLE or DONE.
- `load_count`  in  INS_ADDRESS+1: number of word pairs to write. Sampled with `load_start`.
- `s_valid`  in  1: stream word valid.
- `s_data`  in  INS_W: stream word.
- `s_ready`  out  1: loader accepts `s_data` this cycle.
- `enable_load_ex_mem`  out  1: memory write strobe, high exactly one cycle per pair.
- `InstExMemAddress`  out  INS_ADDRESS: write address.
- `InstExMemData1`  out  INS_W: first word of the pair.
- `InstExMemData2`  out  INS_W: second word of the pair.
- `busy`  out  1: session in progress (any state other than IDLE or DONE).
- `done`  out  1: last session completed; held until the next accepted `load_start`.
- `checksum`  out  INS_W: XOR of all accepted words (see Configuration).

## Operation

- FSM states: IDLE, FILL1, FILL2, WRITE, DONE.
- IDLE/DONE: when `load_start`=1:
  - Latch the count, saturated to 2^INS_ADDRESS.
  - Clear the address and pair counters; clear `done`.
  - Go to FILL1, or straight to DONE if the count is 0.
- FILL1: `s_ready`=1. On handshake (`s_valid`&`s_ready`), capture `s_data` into the Data1 register and go to FILL2.
- FILL2: `s_ready`=1. On handshake, capture `s_data` into the Data2 register and go to WRITE.
- WRITE:
  - `s_ready`=0 and `enable_load_ex_mem`=1.
  - Address, Data1 and Data2 are stable for the whole cycle.
  - Next cycle: address +1 and pair counter +1. If the pair counter equals the count, go to DONE; otherwise go to FILL1.
- Address arithmetic: INS_ADDRESS bits, starting at 0. Saturation of the count means the address never wraps within a session.
- Outside WRITE, the address and data outputs hold their last values. `enable_load_ex_mem` is 0.
- `load_start` while `busy` is ignored and does not disturb the session.
- `s_valid` without `s_ready` (IDLE, WRITE, DONE): the word is not consumed.
- Reset mid-session aborts the session:
  - No write is issued.
  - A partial pair is discarded.
  - All state returns to reset values.

## Timing

- Reset values: state IDLE; `s_ready`=0, `enable_load_ex_mem`=0, `busy`=0, `done`=0; address, data and `checksum` all 0.
- The first FILL1 cycle (`s_ready`=1) is the cycle after `load_start` is accepted.
- `enable_load_ex_mem` rises the cycle after the second handshake of a pair.
- Peak throughput: 2 words per 3 cycles.
- `done` rises the cycle after the final WRITE. `busy` falls in that same cycle.
- Zero count: `done`=1 the cycle after `load_start`, with no write and `busy` never high.
- `s_valid` may drop at any time; the FSM waits in FILL1/FILL2 indefinitely.

## Configuration

- `IMEM_LOADER_CHECKSUM_EN` defined:
  - `checksum` is a register cleared on an accepted `load_start`.
  - It XORs in every accepted `s_data`.
  - Its final value is valid when `done`=1.
- Not defined: `checksum` is tied to 0 and no accumulator logic is built. All other behaviour is identical.

## Test plan

- Reset, then `load_count`=2 and words 0xA, 0xB, 0xC, 0xD streamed with `s_valid` held high. Expect:
  - Write at address 0 with Data1=0xA, Data2=0xB.
  - Write at address 1 with Data1=0xC, Data2=0xD.
  - Each strobe exactly 1 cycle; `done`=1 after the second write. With the macro, `checksum`=0x0.
- `load_count`=1 with `s_valid` toggled every other cycle. Expect a single write at address 0 only after both handshakes, and the FSM stalls in FILL1/FILL2 while `s_valid`=0.
- `load_count`=0. Expect `done`=1 on the next cycle, with no `enable_load_ex_mem` and `busy` never 1.
- `load_start` pulsed again mid-session with `load_count`=5. Expect it ignored: the original count completes and the addresses stay contiguous.
- `rst_n`=0 asserted after the first word of a pair. Expect no write, all outputs at reset values, and a new session starting again at address 0.
- `load_count`=1023 with `INS_ADDRESS`=9. Expect it saturated to 512 writes, the last at address 511, then DONE.
